// File: rtl/miriscv_decode_if.sv
// ---------------------------------------------------------------------------
// miriscv_decode_if
//   Bundle between fetch, decode and execute for the RV32I main decoder.
//   master: the decoder (consumes the instruction, drives the control word).
//   slave : the surrounding pipeline (drives the instruction, consumes control).
// ---------------------------------------------------------------------------
interface miriscv_decode_if;

  localparam int ALU_OP_WIDTH = 5;

  logic [31:0]             fetched_instr_i;
  logic [1:0]              ex_op_a_sel_o;
  logic [2:0]              ex_op_b_sel_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [2:0]              mem_size_o;
  logic                    gpr_we_a_o;
  logic                    wb_src_sel_o;
  logic                    illegal_instr_o;
  logic                    branch_o;
  logic                    jal_o;
  logic                    jalr_o;

  modport master (
    input  fetched_instr_i,
    output ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
    output mem_req_o, mem_we_o, mem_size_o,
    output gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
    output branch_o, jal_o, jalr_o
  );

  modport slave (
    output fetched_instr_i,
    input  ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
    input  mem_req_o, mem_we_o, mem_size_o,
    input  gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
    input  branch_o, jal_o, jalr_o
  );

endinterface

// File: rtl/miriscv_decode.sv
// ---------------------------------------------------------------------------
// miriscv_decode
//   Main RV32I instruction decoder. The control word is decoded
//   combinationally and registered, giving one cycle of latency.
//   Optional build macro:
//     MIRISCV_FENCE_SYSTEM_NOP_EN - MISC_MEM and SYSTEM decode as a legal NOP;
//                                   when undefined they are flagged illegal.
// ---------------------------------------------------------------------------
module miriscv_decode (
  input  logic            clk_i,
  input  logic            rst_n_i,
  miriscv_decode_if.master dec_if
);

  localparam int ALU_OP_WIDTH = 5;

  // Major opcodes, instruction bits [6:2]
  localparam logic [4:0] OPC_LOAD     = 5'b00000;
  localparam logic [4:0] OPC_MISC_MEM = 5'b00011;
  localparam logic [4:0] OPC_OP_IMM   = 5'b00100;
  localparam logic [4:0] OPC_AUIPC    = 5'b00101;
  localparam logic [4:0] OPC_STORE    = 5'b01000;
  localparam logic [4:0] OPC_OP       = 5'b01100;
  localparam logic [4:0] OPC_LUI      = 5'b01101;
  localparam logic [4:0] OPC_BRANCH   = 5'b11000;
  localparam logic [4:0] OPC_JALR     = 5'b11001;
  localparam logic [4:0] OPC_JAL      = 5'b11011;
  localparam logic [4:0] OPC_SYSTEM   = 5'b11100;

  typedef enum logic [1:0] {
    OP_A_RS1     = 2'd0,
    OP_A_CURR_PC = 2'd1,
    OP_A_ZERO    = 2'd2
  } op_a_sel_e;

  typedef enum logic [2:0] {
    OP_B_RS2   = 3'd0,
    OP_B_IMM_I = 3'd1,
    OP_B_IMM_U = 3'd2,
    OP_B_IMM_S = 3'd3,
    OP_B_INCR  = 3'd4
  } op_b_sel_e;

  typedef enum logic [ALU_OP_WIDTH-1:0] {
    ALU_ADD  = 5'b00000,
    ALU_SLL  = 5'b00001,
    ALU_SLTS = 5'b00010,
    ALU_SLTU = 5'b00011,
    ALU_XOR  = 5'b00100,
    ALU_SRL  = 5'b00101,
    ALU_OR   = 5'b00110,
    ALU_AND  = 5'b00111,
    ALU_SUB  = 5'b01000,
    ALU_SRA  = 5'b01101,
    ALU_EQ   = 5'b11000,
    ALU_NE   = 5'b11001,
    ALU_LTS  = 5'b11100,
    ALU_GES  = 5'b11101,
    ALU_LTU  = 5'b11110,
    ALU_GEU  = 5'b11111
  } alu_op_e;

  localparam logic [2:0] SIZE_W      = 3'd2;
  localparam logic       WB_EX       = 1'b0;
  localparam logic       WB_LSU      = 1'b1;
  localparam logic [6:0] FUNCT7_ZERO = 7'h00;
  localparam logic [6:0] FUNCT7_ALT  = 7'h20;

  typedef struct packed {
    op_a_sel_e  op_a;
    op_b_sel_e  op_b;
    alu_op_e    alu;
    logic       mem_req;
    logic       mem_we;
    logic [2:0] mem_size;
    logic       gpr_we;
    logic       wb_src;
    logic       illegal;
    logic       branch;
    logic       jal;
    logic       jalr;
  } ctrl_t;

  // Bubble control word: no side effects anywhere in the pipeline.
  localparam ctrl_t CTRL_NOP = '{
    op_a:     OP_A_RS1,
    op_b:     OP_B_RS2,
    alu:      ALU_ADD,
    mem_req:  1'b0,
    mem_we:   1'b0,
    mem_size: SIZE_W,
    gpr_we:   1'b0,
    wb_src:   WB_EX,
    illegal:  1'b0,
    branch:   1'b0,
    jal:      1'b0,
    jalr:     1'b0
  };

  // Base ALU operation selected by funct3 for register/immediate arithmetic;
  // the shift-right slot defaults to logical and is overridden for SRA/SRAI.
  function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3);
    alu_op_e op;
    case (funct3)
      3'd0:    op = ALU_ADD;
      3'd1:    op = ALU_SLL;
      3'd2:    op = ALU_SLTS;
      3'd3:    op = ALU_SLTU;
      3'd4:    op = ALU_XOR;
      3'd5:    op = ALU_SRL;
      3'd6:    op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

  logic [31:0] w_instr;
  logic [4:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic        w_unused;
  ctrl_t       w_ctrl;
  ctrl_t       r_ctrl;

  assign w_instr  = dec_if.fetched_instr_i;
  assign w_opcode = w_instr[6:2];
  assign w_funct3 = w_instr[14:12];
  assign w_funct7 = w_instr[31:25];
  // Register specifiers and immediates are extracted elsewhere in the core.
  assign w_unused = ^{w_instr[24:15], w_instr[11:7]};

  // Combinational decode of the current instruction into a control word.
  always_comb begin
    // NOTE: the whole word is defaulted first so no path through the case
    // can leave a field unassigned and infer a latch.
    w_ctrl = CTRL_NOP;

    case (w_opcode)
      OPC_LOAD: begin
        w_ctrl.op_b     = OP_B_IMM_I;
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_size = w_funct3;
        w_ctrl.gpr_we   = 1'b1;
        w_ctrl.wb_src   = WB_LSU;
        if (w_funct3 == 3'd3 || w_funct3 == 3'd6 || w_funct3 == 3'd7)
          w_ctrl.illegal = 1'b1;
      end

      OPC_STORE: begin
        w_ctrl.op_b     = OP_B_IMM_S;
        w_ctrl.mem_req  = 1'b1;
        w_ctrl.mem_we   = 1'b1;
        w_ctrl.mem_size = w_funct3;
        if (w_funct3 >= 3'd3)
          w_ctrl.illegal = 1'b1;
      end

      OPC_OP_IMM: begin
        w_ctrl.op_b   = OP_B_IMM_I;
        w_ctrl.gpr_we = 1'b1;
        w_ctrl.alu    = alu_from_funct3(w_funct3);
        // Only the shift-immediates use funct7; it must name a valid shift.
        if (w_funct3 == 3'd1) begin
          if (w_funct7 != FUNCT7_ZERO) w_ctrl.illegal = 1'b1;
        end else if (w_funct3 == 3'd5) begin
          if (w_funct7 == FUNCT7_ALT)       w_ctrl.alu     = ALU_SRA;
          else if (w_funct7 != FUNCT7_ZERO) w_ctrl.illegal = 1'b1;
        end
      end

      OPC_OP: begin
        w_ctrl.gpr_we = 1'b1;
        if (w_funct7 == FUNCT7_ZERO) begin
          w_ctrl.alu = alu_from_funct3(w_funct3);
        end else if (w_funct7 == FUNCT7_ALT && w_funct3 == 3'd0) begin
          w_ctrl.alu = ALU_SUB;
        end else if (w_funct7 == FUNCT7_ALT && w_funct3 == 3'd5) begin
          w_ctrl.alu = ALU_SRA;
        end else begin
          w_ctrl.illegal = 1'b1;
        end
      end

      OPC_LUI: begin
        w_ctrl.op_a   = OP_A_ZERO;
        w_ctrl.op_b   = OP_B_IMM_U;
        w_ctrl.gpr_we = 1'b1;
      end

      OPC_AUIPC: begin
        w_ctrl.op_a   = OP_A_CURR_PC;
        w_ctrl.op_b   = OP_B_IMM_U;
        w_ctrl.gpr_we = 1'b1;
      end

      OPC_JAL: begin
        w_ctrl.op_a   = OP_A_CURR_PC;
        w_ctrl.op_b   = OP_B_INCR;
        w_ctrl.gpr_we = 1'b1;
        w_ctrl.jal    = 1'b1;
      end

      OPC_JALR: begin
        w_ctrl.op_a   = OP_A_CURR_PC;
        w_ctrl.op_b   = OP_B_INCR;
        w_ctrl.gpr_we = 1'b1;
        w_ctrl.jalr   = 1'b1;
        if (w_funct3 != 3'd0)
          w_ctrl.illegal = 1'b1;
      end

      OPC_BRANCH: begin
        w_ctrl.branch = 1'b1;
        case (w_funct3)
          3'd0:    w_ctrl.alu = ALU_EQ;
          3'd1:    w_ctrl.alu = ALU_NE;
          3'd4:    w_ctrl.alu = ALU_LTS;
          3'd5:    w_ctrl.alu = ALU_GES;
          3'd6:    w_ctrl.alu = ALU_LTU;
          3'd7:    w_ctrl.alu = ALU_GEU;
          default: w_ctrl.illegal = 1'b1;
        endcase
      end

      OPC_MISC_MEM, OPC_SYSTEM: begin
`ifdef MIRISCV_FENCE_SYSTEM_NOP_EN
        // FENCE / ECALL / EBREAK / CSR ops retire as plain bubbles.
        w_ctrl = CTRL_NOP;
`else
        w_ctrl.illegal = 1'b1;
`endif
      end

      default: w_ctrl.illegal = 1'b1;
    endcase

    // Compressed or malformed encodings are never supported.
    if (w_instr[1:0] != 2'b11)
      w_ctrl.illegal = 1'b1;

    // An illegal instruction must not produce any side effect downstream.
    if (w_ctrl.illegal) begin
      w_ctrl         = CTRL_NOP;
      w_ctrl.illegal = 1'b1;
    end
  end

  // Output register: one cycle of decode latency, synchronous reset to NOP.
  always_ff @(posedge clk_i) begin
    // NOTE: state is updated with non-blocking assignments so every
    // register samples pre-edge values regardless of statement order.
    if (!rst_n_i) r_ctrl <= CTRL_NOP;
    else          r_ctrl <= w_ctrl;
  end

  assign dec_if.ex_op_a_sel_o   = r_ctrl.op_a;
  assign dec_if.ex_op_b_sel_o   = r_ctrl.op_b;
  assign dec_if.alu_op_o        = r_ctrl.alu;
  assign dec_if.mem_req_o       = r_ctrl.mem_req;
  assign dec_if.mem_we_o        = r_ctrl.mem_we;
  assign dec_if.mem_size_o      = r_ctrl.mem_size;
  assign dec_if.gpr_we_a_o      = r_ctrl.gpr_we;
  assign dec_if.wb_src_sel_o    = r_ctrl.wb_src;
  assign dec_if.illegal_instr_o = r_ctrl.illegal;
  assign dec_if.branch_o        = r_ctrl.branch;
  assign dec_if.jal_o           = r_ctrl.jal;
  assign dec_if.jalr_o          = r_ctrl.jalr;

endmodule

// File: tb/tb_miriscv_decode.sv
// ---------------------------------------------------------------------------
// tb_miriscv_decode
//   Self-checking bench for the RV32I main decoder: directed cases followed by
//   randomized instructions compared against a reference model of the
//   decoding rules. Honours MIRISCV_FENCE_SYSTEM_NOP_EN like the design.
// ---------------------------------------------------------------------------
module tb_miriscv_decode;

`ifdef MIRISCV_FENCE_SYSTEM_NOP_EN
  localparam bit FENCE_LEGAL = 1'b1;
`else
  localparam bit FENCE_LEGAL = 1'b0;
`endif

  logic clk_i;
  logic rst_n_i;

  miriscv_decode_if dec_if ();

  miriscv_decode dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .dec_if  (dec_if.master)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Control word packed as {op_a[2], op_b[3], alu[5], req, we, size[3],
  // gpr_we, wb, illegal, branch, jal, jalr} = 21 bits.
  function automatic logic [20:0] pack(
    input logic [1:0] a, input logic [2:0] b, input logic [4:0] alu,
    input logic req, input logic we, input logic [2:0] size,
    input logic gpr, input logic wb, input logic ill,
    input logic br, input logic jl, input logic jr);
    return {a, b, alu, req, we, size, gpr, wb, ill, br, jl, jr};
  endfunction

  function automatic logic [20:0] observed();
    return pack(dec_if.ex_op_a_sel_o, dec_if.ex_op_b_sel_o, dec_if.alu_op_o,
                dec_if.mem_req_o, dec_if.mem_we_o, dec_if.mem_size_o,
                dec_if.gpr_we_a_o, dec_if.wb_src_sel_o, dec_if.illegal_instr_o,
                dec_if.branch_o, dec_if.jal_o, dec_if.jalr_o);
  endfunction

  localparam logic [20:0] NOP_WORD = {2'd0, 3'd0, 5'b00000, 1'b0, 1'b0, 3'd2,
                                      1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};

  // Reference model: lookup tables indexed by funct3 plus legality rules.
  function automatic logic [20:0] model(input logic [31:0] ins);
    logic [4:0] arith_alu [8];
    logic [4:0] br_alu    [8];
    logic [4:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [1:0] a;
    logic [2:0] b;
    logic [4:0] alu;
    logic       req, we, gpr, wb, br, jl, jr, ok;
    logic [2:0] size;
    arith_alu = '{5'b00000, 5'b00001, 5'b00010, 5'b00011,
                  5'b00100, 5'b00101, 5'b00110, 5'b00111};
    br_alu    = '{5'b11000, 5'b11001, 5'b00000, 5'b00000,
                  5'b11100, 5'b11101, 5'b11110, 5'b11111};
    opc = ins[6:2]; f3 = ins[14:12]; f7 = ins[31:25];
    a = 2'd0; b = 3'd0; alu = 5'b00000; size = 3'd2;
    req = 0; we = 0; gpr = 0; wb = 0; br = 0; jl = 0; jr = 0; ok = 1;
    if (opc == 5'b00000) begin        // load
      b = 1; req = 1; size = f3; gpr = 1; wb = 1;
      ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    end else if (opc == 5'b01000) begin // store
      b = 3; req = 1; we = 1; size = f3;
      ok = (f3 < 3);
    end else if (opc == 5'b00100) begin // op-imm
      b = 1; gpr = 1; alu = arith_alu[f3];
      if (f3 == 1) ok = (f7 == 7'h00);
      if (f3 == 5) begin
        ok = (f7 == 7'h00) || (f7 == 7'h20);
        if (f7 == 7'h20) alu = 5'b01101;
      end
    end else if (opc == 5'b01100) begin // op
      gpr = 1;
      if (f7 == 7'h00) alu = arith_alu[f3];
      else if (f7 == 7'h20 && f3 == 0) alu = 5'b01000;
      else if (f7 == 7'h20 && f3 == 5) alu = 5'b01101;
      else ok = 0;
    end else if (opc == 5'b01101) begin a = 2; b = 2; gpr = 1;
    end else if (opc == 5'b00101) begin a = 1; b = 2; gpr = 1;
    end else if (opc == 5'b11011) begin a = 1; b = 4; gpr = 1; jl = 1;
    end else if (opc == 5'b11001) begin a = 1; b = 4; gpr = 1; jr = 1; ok = (f3 == 0);
    end else if (opc == 5'b11000) begin br = 1; alu = br_alu[f3]; ok = !(f3 inside {3'd2, 3'd3});
    end else if (opc == 5'b00011 || opc == 5'b11100) begin ok = FENCE_LEGAL;
    end else begin ok = 0;
    end
    if (ins[1:0] != 2'b11) ok = 0;
    if (!ok) return NOP_WORD | 21'd1 << 3;
    return pack(a, b, alu, req, we, size, gpr, wb, 1'b0, br, jl, jr);
  endfunction

  // Present one instruction, let one edge register it, sample 1 time unit later.
  task automatic step(input logic [31:0] ins);
    dec_if.fetched_instr_i = ins;
    @(posedge clk_i);
    #1;
  endtask

  task automatic step_check(input logic [31:0] ins, input string tag);
    step(ins);
    check(tag, {11'd0, observed()}, {11'd0, model(ins)});
  endtask

  logic [4:0] opc_pool [11] = '{5'b00000, 5'b01000, 5'b00100, 5'b01100, 5'b01101,
                                5'b00101, 5'b11011, 5'b11001, 5'b11000, 5'b00011,
                                5'b11100};

  initial begin
    rst_n_i = 1'b0;
    dec_if.fetched_instr_i = 32'h0050_0093;

    // Reset held for two edges with legal instructions present.
    step(32'h0050_0093);
    check("reset_edge1", {11'd0, observed()}, {11'd0, NOP_WORD});
    step(32'h0011_2023);
    check("reset_edge2", {11'd0, observed()}, {11'd0, NOP_WORD});
    check("reset_illegal", {31'd0, dec_if.illegal_instr_o}, 32'd0);

    // First post-reset edge reflects the instruction present.
    rst_n_i = 1'b1;
    step(32'h0050_0093);
    check("addi.op_a",   {30'd0, dec_if.ex_op_a_sel_o}, 32'd0);
    check("addi.op_b",   {29'd0, dec_if.ex_op_b_sel_o}, 32'd1);
    check("addi.alu",    {27'd0, dec_if.alu_op_o},      32'd0);
    check("addi.gpr_we", {31'd0, dec_if.gpr_we_a_o},    32'd1);
    check("addi.wb",     {31'd0, dec_if.wb_src_sel_o},  32'd0);
    check("addi.ill",    {31'd0, dec_if.illegal_instr_o}, 32'd0);

    step(32'h0011_2023);
    check("sw.req",  {31'd0, dec_if.mem_req_o},     32'd1);
    check("sw.we",   {31'd0, dec_if.mem_we_o},      32'd1);
    check("sw.size", {29'd0, dec_if.mem_size_o},    32'd2);
    check("sw.op_b", {29'd0, dec_if.ex_op_b_sel_o}, 32'd3);
    check("sw.gpr",  {31'd0, dec_if.gpr_we_a_o},    32'd0);

    step(32'h0000_B083);
    check("ld3.ill", {31'd0, dec_if.illegal_instr_o}, 32'd1);
    check("ld3.req", {31'd0, dec_if.mem_req_o},       32'd0);

    step(32'h0020_E063);
    check("bltu.br",   {31'd0, dec_if.branch_o},      32'd1);
    check("bltu.alu",  {27'd0, dec_if.alu_op_o},      32'b11110);
    check("bltu.op_b", {29'd0, dec_if.ex_op_b_sel_o}, 32'd0);
    check("bltu.gpr",  {31'd0, dec_if.gpr_we_a_o},    32'd0);

    step(32'h0000_90E7);
    check("jalr1.ill",  {31'd0, dec_if.illegal_instr_o}, 32'd1);
    check("jalr1.jalr", {31'd0, dec_if.jalr_o},          32'd0);

    step(32'h4010_D093);
    check("srai.alu", {27'd0, dec_if.alu_op_o}, 32'b01101);
    step(32'h0210_D093);
    check("srai_bad.ill", {31'd0, dec_if.illegal_instr_o}, 32'd1);
    step(32'h4020_8033);
    check("sub.alu", {27'd0, dec_if.alu_op_o}, 32'b01000);

    step(32'h1234_5037);
    check("lui.op_a", {30'd0, dec_if.ex_op_a_sel_o}, 32'd2);
    check("lui.op_b", {29'd0, dec_if.ex_op_b_sel_o}, 32'd2);
    step(32'h0000_006F);
    check("jal.op_a", {30'd0, dec_if.ex_op_a_sel_o}, 32'd1);
    check("jal.op_b", {29'd0, dec_if.ex_op_b_sel_o}, 32'd4);
    check("jal.jal",  {31'd0, dec_if.jal_o},         32'd1);
    step(32'h0000_0000);
    check("zero.ill", {31'd0, dec_if.illegal_instr_o}, 32'd1);

    step(32'h0000_000F);
    check("fence.ill", {31'd0, dec_if.illegal_instr_o}, {31'd0, !FENCE_LEGAL});
    check("fence.gpr", {31'd0, dec_if.gpr_we_a_o}, 32'd0);
    check("fence.req", {31'd0, dec_if.mem_req_o},  32'd0);

    // Reset asserted mid-stream: NOP at the next edge and held.
    rst_n_i = 1'b0;
    step(32'h0000_006F);
    check("midrst_edge1", {11'd0, observed()}, {11'd0, NOP_WORD});
    step(32'h0000_0000);
    check("midrst_edge2", {11'd0, observed()}, {11'd0, NOP_WORD});
    rst_n_i = 1'b1;

    // Randomized instructions biased towards real opcodes and funct7 values.
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] ins;
      int          sel;
      ins = $urandom;
      sel = $urandom_range(0, 11);
      if (sel < 11) ins[6:2] = opc_pool[sel];
      if ($urandom_range(0, 15) != 0) ins[1:0] = 2'b11;
      case ($urandom_range(0, 3))
        0:       ins[31:25] = 7'h00;
        1:       ins[31:25] = 7'h20;
        default: ;
      endcase
      if ($urandom_range(0, 63) == 0) begin
        rst_n_i = 1'b0;
        step(ins);
        check("rand_reset", {11'd0, observed()}, {11'd0, NOP_WORD});
        rst_n_i = 1'b1;
      end else begin
        step_check(ins, $sformatf("rand[%0d] instr=%08h", i, ins));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
